// File: rtl/fft_in_framer.sv
// fft_in_framer: buffers one frame of real 16-bit samples, sends the FFT
// config word once per reset, then streams each full frame over AXI-Stream.
module fft_in_framer #(
  parameter int          FRAME_LEN = 2048,
  parameter int          IDX_W     = 11,
  parameter int          SHIFT     = 10,
  parameter logic [15:0] CFG_WORD  = 16'h0001
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_sample_valid,
  input  logic [15:0]      s_sample_data,
  output logic             s_sample_ready,
  output logic             m_axis_config_tvalid,
  input  logic             m_axis_config_tready,
  output logic [15:0]      m_axis_config_tdata,
  output logic             m_axis_data_tvalid,
  input  logic             m_axis_data_tready,
  output logic [63:0]      m_axis_data_tdata,
  output logic             m_axis_data_tlast,
  output logic [IDX_W-1:0] m_axis_data_tuser,
  output logic             frame_sent
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {CFG, FILL, DRAIN} state_t;

  state_t           state;
  logic [15:0]      mem [FRAME_LEN];
  logic [IDX_W-1:0] wr_cnt;
  logic [IDX_W-1:0] rd_cnt;
  logic             rd_pend;
  logic             cfg_valid;
  logic [15:0]      cfg_data;
  logic             s_ready;
  logic [15:0]      r_data;
  logic             r_valid;
  logic [IDX_W-1:0] r_idx;
  logic             o_valid;
  logic [31:0]      o_re;
  logic [IDX_W-1:0] o_idx;
  logic             o_last;
  logic             sent;

  logic             wr_en;
  logic             o_en;
  logic             r_en;
  logic             rd_en;
  logic [27:0]      re28;
  logic [31:0]      re32;

  assign wr_en = (state == FILL) && s_ready && s_sample_valid;
  assign o_en  = !o_valid || m_axis_data_tready;
  assign r_en  = !r_valid || o_en;
  assign rd_en = (state == DRAIN) && rd_pend && r_en;

  assign re28 = {{12{r_data[15]}}, r_data} << SHIFT;
  assign re32 = {{4{re28[27]}}, re28};

  // Buffer RAM: no reset, contents are only trusted after a full fill
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_cnt] <= s_sample_data;
    if (rd_en) r_data <= mem[rd_cnt];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= CFG;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      rd_pend   <= 1'b0;
      cfg_valid <= 1'b0;
      cfg_data  <= '0;
      s_ready   <= 1'b0;
      r_valid   <= 1'b0;
      r_idx     <= '0;
      o_valid   <= 1'b0;
      o_re      <= '0;
      o_idx     <= '0;
      o_last    <= 1'b0;
      sent      <= 1'b0;
    end else begin
      sent     <= 1'b0;
      cfg_data <= CFG_WORD;
      unique case (state)
        CFG: begin
          cfg_valid <= 1'b1;
          if (cfg_valid && m_axis_config_tready) begin
            cfg_valid <= 1'b0;
            s_ready   <= 1'b1;
            state     <= FILL;
          end
        end
        FILL: begin
          if (wr_en) begin
            wr_cnt <= wr_cnt + 1'b1;
            if (wr_cnt == LAST) begin
              s_ready <= 1'b0;
              rd_pend <= 1'b1;
              rd_cnt  <= '0;
              state   <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // Read stage only advances when the output register frees up
          if (r_en) begin
            r_valid <= rd_pend;
            r_idx   <= rd_cnt;
            if (rd_pend) begin
              rd_cnt <= rd_cnt + 1'b1;
              if (rd_cnt == LAST) rd_pend <= 1'b0;
            end
          end
          if (o_en) begin
            o_valid <= r_valid;
            o_re    <= re32;
            o_idx   <= r_idx;
            o_last  <= r_valid && (r_idx == LAST);
          end
          if (o_valid && m_axis_data_tready && o_last) begin
            sent    <= 1'b1;
            s_ready <= 1'b1;
            state   <= FILL;
          end
        end
        default: state <= CFG;
      endcase
    end
  end

  assign s_sample_ready       = s_ready;
  assign m_axis_config_tvalid = cfg_valid;
  assign m_axis_config_tdata  = cfg_data;
  assign m_axis_data_tvalid   = o_valid;
  assign m_axis_data_tdata    = {32'h0, o_re};
  assign m_axis_data_tlast    = o_last;
  assign m_axis_data_tuser    = o_idx;
  assign frame_sent           = sent;

endmodule

// File: tb/tb_fft_in_framer.sv
// tb_fft_in_framer: directed bench for fft_in_framer with an expected-value
// table per frame; inputs change and outputs are sampled on the falling edge.
module tb_fft_in_framer;

  localparam int N = 2048;

  logic        clk = 1'b0;
  logic        reset;
  logic        s_valid;
  logic [15:0] s_data;
  logic        s_ready;
  logic        cfg_tvalid;
  logic        cfg_tready;
  logic [15:0] cfg_tdata;
  logic        d_tvalid;
  logic        d_tready;
  logic [63:0] d_tdata;
  logic        d_tlast;
  logic [10:0] d_tuser;
  logic        frame_sent;

  logic        rdy_fix;
  logic        rnd_en;
  logic        rnd_bit;

  int          n_tests;
  int          n_fail;
  logic [15:0] cur [N];
  logic [63:0] got [N];

  assign d_tready = rnd_en ? rnd_bit : rdy_fix;

  fft_in_framer dut (
    .clk                  (clk),
    .reset                (reset),
    .s_sample_valid       (s_valid),
    .s_sample_data        (s_data),
    .s_sample_ready       (s_ready),
    .m_axis_config_tvalid (cfg_tvalid),
    .m_axis_config_tready (cfg_tready),
    .m_axis_config_tdata  (cfg_tdata),
    .m_axis_data_tvalid   (d_tvalid),
    .m_axis_data_tready   (d_tready),
    .m_axis_data_tdata    (d_tdata),
    .m_axis_data_tlast    (d_tlast),
    .m_axis_data_tuser    (d_tuser),
    .frame_sent           (frame_sent)
  );

  always #5 clk = ~clk;

  initial begin
    rnd_bit = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      rnd_bit = ($urandom_range(0, 9) < 3);
    end
  end

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [63:0] re_of(input logic [15:0] d);
    int v;
    v = int'($signed(d)) * 1024;
    return {32'h0, v};
  endfunction

  task automatic chk_all_zero(input string tag);
    chk(tag, {s_ready, cfg_tvalid, cfg_tdata, d_tvalid, d_tdata,
              d_tlast, d_tuser, frame_sent}, '0);
  endtask

  task automatic cfg_phase(input int waits);
    int hs;
    hs = 0;
    cfg_tready = 1'b0;
    reset = 1'b1;
    tick();
    for (int i = 0; i < waits; i++) begin
      chk("cfg_wait", {cfg_tvalid, cfg_tdata, d_tvalid, s_ready},
          {1'b1, 16'h0001, 1'b0, 1'b0});
      tick();
    end
    cfg_tready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (cfg_tvalid && cfg_tready) hs++;
      tick();
    end
    chk("cfg_handshakes", 32'(hs), 32'd1);
    chk("cfg_then_ready", {cfg_tvalid, s_ready}, 2'b01);
  endtask

  // Feeds cur[] in order; keep_bad leaves junk valid on the input afterwards
  task automatic feed(input bit lat, input bit keep_bad);
    int g;
    for (int i = 0; i < N; i++) begin
      s_valid = 1'b1;
      s_data  = cur[i];
      g = 0;
      while (!s_ready && g < 200) begin
        tick();
        g++;
      end
      if (g == 200) begin
        chk("feed_timeout", 32'(i), 32'hFFFF_FFFF);
        s_valid = 1'b0;
        return;
      end
      tick();
      if (i == 0) chk("sent_single", frame_sent, 1'b0);
    end
    s_valid = keep_bad;
    s_data  = 16'hBAD0;
    if (lat) begin
      chk("lat_e0", d_tvalid, 1'b0);
      tick();
      chk("lat_e1", d_tvalid, 1'b0);
      tick();
      chk("lat_e2", d_tvalid, 1'b1);
    end
  endtask

  task automatic drain(input int stop_at);
    int          beat;
    int          b;
    bit          stall;
    bit          done;
    logic [75:0] prev;
    beat  = 0;
    stall = 1'b0;
    done  = 1'b0;
    prev  = '0;
    for (int cyc = 0; cyc < 40000; cyc++) begin
      if (stall)
        chk("stall_hold", {d_tvalid, d_tlast, d_tuser, d_tdata},
            {1'b1, prev});
      if (frame_sent) begin
        done = 1'b1;
        break;
      end
      if (d_tvalid && d_tready) begin
        b = beat & (N - 1);
        chk("beat", {cfg_tvalid, s_ready, d_tlast, d_tuser, d_tdata},
            {1'b0, 1'b0, beat == N - 1, 11'(beat), re_of(cur[b])});
        got[b] = d_tdata;
        beat++;
        if (beat == stop_at) return;
      end
      stall = d_tvalid && !d_tready;
      prev  = {d_tlast, d_tuser, d_tdata};
      tick();
    end
    if (!done) begin
      chk("drain_timeout", 32'(beat), 32'(N));
      return;
    end
    chk("beat_count", 32'(beat), 32'(N));
    chk("refill_ready", {s_ready, d_tvalid}, 2'b10);
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    reset      = 1'b0;
    s_valid    = 1'b0;
    s_data     = '0;
    cfg_tready = 1'b0;
    rdy_fix    = 1'b0;
    rnd_en     = 1'b0;
    repeat (3) tick();
    chk_all_zero("reset_state");

    cfg_phase(5);

    rdy_fix = 1'b1;
    for (int i = 0; i < N; i++) cur[i] = 16'(i);
    feed(1'b1, 1'b0);
    drain(0);

    for (int i = 0; i < N; i++) cur[i] = 16'(i * 37 + 5);
    cur[0] = 16'h8000;
    cur[1] = 16'h7FFF;
    feed(1'b0, 1'b0);
    drain(0);
    chk("re_min", got[0], 64'h0000_0000_FE00_0000);
    chk("re_max", got[1], 64'h0000_0000_01FF_FC00);

    for (int i = 0; i < N; i++) cur[i] = 16'($urandom);
    feed(1'b0, 1'b0);
    rnd_en = 1'b1;
    drain(0);
    rnd_en = 1'b0;

    for (int i = 0; i < N; i++) cur[i] = 16'(16'h4000 - i);
    feed(1'b0, 1'b1);
    drain(0);
    for (int i = 0; i < N; i++) cur[i] = 16'(i ^ 16'h0155);
    feed(1'b0, 1'b0);
    drain(0);

    for (int i = 0; i < N; i++) cur[i] = 16'(i * 3);
    feed(1'b0, 1'b0);
    drain(1000);
    reset = 1'b0;
    tick();
    chk_all_zero("mid_drain_reset");
    cfg_phase(2);
    for (int i = 0; i < N; i++) cur[i] = 16'(16'hF000 + i);
    feed(1'b0, 1'b0);
    drain(0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
